// File: rtl/inst_encode.sv
// -----------------------------------------------------------------------------
// inst_encode
//   Encodes one RV32I instruction from its decoded fields and writes it to a
//   byte-wide memory as four little-endian byte writes at base_addr..base_addr+3.
//   Requests with an unknown opcode or an immediate that cannot be represented
//   in the selected format are rejected with a one-cycle ready+err pulse.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   en              start request, sampled only while idle
//   op, rd, rs1, rs2, funct3, funct7, imm
//                   decoded instruction fields (imm is the signed byte offset)
//   base_addr       address of byte 0
//   mem_addr/mem_data/mem_we
//                   registered byte-write port
//   busy            high during the four write cycles
//   ready           one-cycle completion pulse
//   err             qualifies ready: request was rejected
// -----------------------------------------------------------------------------
module inst_encode #(
  parameter int M_WIDTH    = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int INST_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [6:0]            op,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic [31:0]           imm,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [M_WIDTH-1:0]    mem_data,
  output logic                  mem_we,
  output logic                  busy,
  output logic                  ready,
  output logic                  err
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  // Returns {ok, inst}. ok=0 means unknown opcode or unrepresentable immediate.
  function automatic logic [32:0] encode(
    input logic [6:0]  f_op,
    input logic [4:0]  f_rd,
    input logic [4:0]  f_rs1,
    input logic [4:0]  f_rs2,
    input logic [2:0]  f_f3,
    input logic [6:0]  f_f7,
    input logic [31:0] f_imm
  );
    logic        ok;
    logic [31:0] inst;
    ok   = 1'b0;
    inst = 32'd0;
    case (f_op)
      OP_R: begin
        ok   = 1'b1;
        inst = {f_f7, f_rs2, f_rs1, f_f3, f_rd, f_op};
      end
      OP_JALR, OP_LOAD, OP_IMM: begin
        // 12-bit signed: every bit above bit 11 must copy bit 11
        ok   = (f_imm[31:11] == {21{f_imm[11]}});
        inst = {f_imm[11:0], f_rs1, f_f3, f_rd, f_op};
      end
      OP_STORE: begin
        ok   = (f_imm[31:11] == {21{f_imm[11]}});
        inst = {f_imm[11:5], f_rs2, f_rs1, f_f3, f_imm[4:0], f_op};
      end
      OP_BRANCH: begin
        // 13-bit signed, even offset
        ok   = (f_imm[31:12] == {20{f_imm[12]}}) && (f_imm[0] == 1'b0);
        inst = {f_imm[12], f_imm[10:5], f_rs2, f_rs1, f_f3, f_imm[4:1], f_imm[11], f_op};
      end
      OP_LUI, OP_AUIPC: begin
        ok   = (f_imm[11:0] == 12'd0);
        inst = {f_imm[31:12], f_rd, f_op};
      end
      OP_JAL: begin
        // 21-bit signed, even offset
        ok   = (f_imm[31:20] == {12{f_imm[20]}}) && (f_imm[0] == 1'b0);
        inst = {f_imm[20], f_imm[10:1], f_imm[11], f_imm[19:12], f_rd, f_op};
      end
      default: begin
        ok   = 1'b0;
        inst = 32'd0;
      end
    endcase
    return {ok, inst};
  endfunction

  // Little-endian byte k of the captured instruction.
  function automatic logic [M_WIDTH-1:0] byte_of(
    input logic [INST_WIDTH-1:0] word,
    input logic [1:0]            idx
  );
    return M_WIDTH'(word >> {idx, 3'b000});
  endfunction

  state_t                  state_q, state_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [INST_WIDTH-1:0]   inst_q, inst_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [M_WIDTH-1:0]      mem_data_q, mem_data_d;
  logic                    mem_we_q, mem_we_d;
  logic                    busy_q, busy_d;
  logic                    ready_q, ready_d;
  logic                    err_q, err_d;
  logic [32:0]             enc_s;
  logic [1:0]              cnt_nxt_s;

  assign enc_s     = encode(op, rd, rs1, rs2, funct3, funct7, imm);
  assign cnt_nxt_s = cnt_q + 2'd1;

  // Next-state and registered-output logic; cnt_q is the byte index currently
  // on the write port, so the output registers are loaded one cycle ahead.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    inst_d     = inst_q;
    base_d     = base_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_we_d   = 1'b0;
    busy_d     = 1'b0;
    ready_d    = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en) begin
          if (enc_s[32]) begin
            // Capture everything now and present byte 0 on the next cycle.
            inst_d     = INST_WIDTH'(enc_s[31:0]);
            base_d     = base_addr;
            cnt_d      = 2'd0;
            mem_addr_d = base_addr;
            mem_data_d = byte_of(INST_WIDTH'(enc_s[31:0]), 2'd0);
            mem_we_d   = 1'b1;
            busy_d     = 1'b1;
            state_d    = S_WRITE;
          end else begin
            ready_d = 1'b1;
            err_d   = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        if (cnt_q == 2'd3) begin
          ready_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d      = cnt_nxt_s;
          mem_addr_d = base_q + ADDR_WIDTH'(cnt_nxt_s);
          mem_data_d = byte_of(inst_q, cnt_nxt_s);
          mem_we_d   = 1'b1;
          busy_d     = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 2'd0;
      inst_q     <= '0;
      base_q     <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inst_q     <= inst_d;
      base_q     <= base_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_we_q   <= mem_we_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
    end
  end

  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign mem_we   = mem_we_q;
  assign busy     = busy_q;
  assign ready    = ready_q;
  assign err      = err_q;

endmodule

// File: tb/tb_inst_encode.sv
// -----------------------------------------------------------------------------
// tb_inst_encode
//   Self-checking bench for inst_encode: directed examples, rejection cases,
//   re-request during a write, mid-write reset, and randomized requests checked
//   cycle by cycle against a field-arithmetic reference encoder.
// -----------------------------------------------------------------------------
module tb_inst_encode;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [6:0]  op;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic [7:0]  base_addr;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_data;
  logic        mem_we, busy, ready, err;

  int vectors     = 0;
  int miscompares = 0;
  logic [7:0] last_addr, last_data;

  always #5 clk = ~clk;

  inst_encode dut (
    .clk(clk), .rst(rst), .en(en), .op(op), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm), .base_addr(base_addr),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .busy(busy), .ready(ready), .err(err)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Field extraction by shift-and-mask.
  function automatic logic [31:0] fld(input logic [31:0] v, input int hi, input int lo);
    return (v >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
  endfunction

  // Reference encoder: validity from signed numeric ranges, word built by
  // summing shifted fields.
  function automatic bit ref_encode(input logic [6:0] o, input logic [4:0] d,
                                    input logic [4:0] s1, input logic [4:0] s2,
                                    input logic [2:0] f3, input logic [6:0] f7,
                                    input logic [31:0] im, output logic [31:0] inst);
    int  s;
    bit  even;
    bit  ok;
    logic [31:0] base;
    s    = $signed(im);
    even = (im[0] == 1'b0);
    base = (32'(f3) << 12) | 32'(o);
    ok   = 1'b0;
    inst = 32'd0;
    case (o)
      7'h33: begin
        ok = 1'b1;
        inst = (32'(f7) << 25) + (32'(s2) << 20) + (32'(s1) << 15) + base + (32'(d) << 7);
      end
      7'h67, 7'h03, 7'h13: begin
        ok = (s >= -2048) && (s <= 2047);
        inst = (fld(im, 11, 0) << 20) + (32'(s1) << 15) + base + (32'(d) << 7);
      end
      7'h23: begin
        ok = (s >= -2048) && (s <= 2047);
        inst = (fld(im, 11, 5) << 25) + (32'(s2) << 20) + (32'(s1) << 15) + base + (fld(im, 4, 0) << 7);
      end
      7'h63: begin
        ok = (s >= -4096) && (s <= 4095) && even;
        inst = (fld(im, 12, 12) << 31) + (fld(im, 10, 5) << 25) + (32'(s2) << 20) + (32'(s1) << 15)
             + base + (fld(im, 4, 1) << 8) + (fld(im, 11, 11) << 7);
      end
      7'h37, 7'h17: begin
        ok = ((im % 32'd4096) == 32'd0);
        inst = (fld(im, 31, 12) << 12) + (32'(d) << 7) + 32'(o);
      end
      7'h6F: begin
        ok = (s >= -1048576) && (s <= 1048575) && even;
        inst = (fld(im, 20, 20) << 31) + (fld(im, 10, 1) << 21) + (fld(im, 11, 11) << 20)
             + (fld(im, 19, 12) << 12) + (32'(d) << 7) + 32'(o);
      end
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  task automatic set_req(input logic [6:0] o, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] im, input logic [7:0] b);
    op = o; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im; base_addr = b;
  endtask

  task automatic scramble();
    set_req(7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
            7'($urandom), $urandom, 8'($urandom));
  endtask

  // Called at a negedge with fields driven; raises en for one edge and checks
  // every following cycle through the ready pulse. Returns at that negedge.
  task automatic run_req(input logic [31:0] exp_inst, input bit exp_ok, input bit reen);
    logic [7:0] b;
    b  = base_addr;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    scramble();
    if (exp_ok) begin
      for (int k = 0; k < 4; k++) begin
        check("wr_we", 32'(mem_we), 32'd1);
        check("wr_busy", 32'(busy), 32'd1);
        check("wr_ready", 32'(ready), 32'd0);
        check("wr_addr", 32'(mem_addr), 32'((int'(b) + k) % 256));
        check("wr_data", 32'(mem_data), fld(exp_inst, 8 * k + 7, 8 * k));
        if (reen && k == 1) begin
          set_req(7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd0, 8'h80);
          en = 1'b1;
        end else begin
          en = 1'b0;
        end
        @(negedge clk);
      end
      last_addr = 8'((int'(b) + 3) % 256);
      last_data = 8'(fld(exp_inst, 31, 24));
      check("done_ready", 32'(ready), 32'd1);
      check("done_err", 32'(err), 32'd0);
    end else begin
      check("rej_ready", 32'(ready), 32'd1);
      check("rej_err", 32'(err), 32'd1);
    end
    check("end_we", 32'(mem_we), 32'd0);
    check("end_busy", 32'(busy), 32'd0);
    check("hold_addr", 32'(mem_addr), 32'(last_addr));
    check("hold_data", 32'(mem_data), 32'(last_data));
  endtask

  task automatic check_quiet(input string tag);
    check(tag, {28'd0, mem_we, busy, ready, err}, 32'd0);
  endtask

  logic [6:0]  valid_ops [9] = '{7'h33, 7'h67, 7'h03, 7'h13, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
  logic [31:0] bnd [8] = '{32'd2047, 32'hFFFFF800, 32'd2048, 32'hFFFFF7FF,
                           32'd4094, 32'hFFFFF000, 32'h000FFFFE, 32'hFFF00000};

  initial begin
    logic [31:0] exp_inst;
    bit          ok;

    rst = 1'b1;
    en  = 1'b0;
    scramble();
    last_addr = 8'd0;
    last_data = 8'd0;
    @(negedge clk);
    en = 1'b1;                      // reset must win over en
    @(negedge clk);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_data", 32'(mem_data), 32'd0);
    check_quiet("rst_flags");
    en  = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check_quiet("idle_flags");

    // ADDI x1,x2,5
    set_req(7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd5, 8'h10);
    run_req(32'h00510093, 1'b1, 1'b0);
    // ADD x3,x1,x2
    set_req(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 8'h20);
    run_req(32'h002081B3, 1'b1, 1'b0);
    // BEQ x1,x2,-4
    set_req(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC, 8'h30);
    run_req(32'hFE208EE3, 1'b1, 1'b0);
    // LUI x5 with address wrap
    set_req(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 8'hFE);
    run_req(32'h123452B7, 1'b1, 1'b0);

    // Rejections
    set_req(7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'h00000800, 8'h40);
    run_req(32'd0, 1'b0, 1'b0);
    set_req(7'h7F, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd0, 8'h40);
    run_req(32'd0, 1'b0, 1'b0);
    set_req(7'h63, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd3, 8'h40);
    run_req(32'd0, 1'b0, 1'b0);
    @(negedge clk);
    check_quiet("post_rej");

    // en during a write is ignored; en in the ready cycle is accepted
    set_req(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 8'h50);
    run_req(32'h002081B3, 1'b1, 1'b1);
    set_req(7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd5, 8'h60);
    run_req(32'h00510093, 1'b1, 1'b0);
    @(negedge clk);
    check_quiet("post_chain");

    // Reset during write aborts
    set_req(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 8'h70);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    check("abort_we1", 32'(mem_we), 32'd1);
    @(negedge clk);
    check("abort_we2", 32'(mem_we), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_addr", 32'(mem_addr), 32'd0);
    check("abort_data", 32'(mem_data), 32'd0);
    last_addr = 8'd0;
    last_data = 8'd0;
    for (int i = 0; i < 6; i++) begin
      check_quiet("abort_quiet");
      @(negedge clk);
    end
    set_req(7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd5, 8'h10);
    run_req(32'h00510093, 1'b1, 1'b0);

    // Randomized requests
    for (int n = 0; n < 80; n++) begin
      logic [6:0]  o;
      logic [31:0] im;
      o = ($urandom_range(0, 7) == 0) ? 7'($urandom) : valid_ops[$urandom_range(0, 8)];
      case ($urandom_range(0, 4))
        0:       im = $urandom;
        1:       im = 32'($urandom_range(0, 4095)) - 32'd2048;
        2:       im = $urandom & 32'hFFFFF000;
        3:       im = 32'($urandom_range(0, 2097151)) - 32'd1048576;
        default: im = bnd[$urandom_range(0, 7)];
      endcase
      set_req(o, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom),
              im, 8'($urandom));
      ok = ref_encode(op, rd, rs1, rs2, funct3, funct7, imm, exp_inst);
      run_req(exp_inst, ok, 1'($urandom_range(0, 1)));
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        @(negedge clk);
        check_quiet("gap_quiet");
      end
    end

    @(negedge clk);
    check_quiet("final_quiet");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
